// File: rtl/splitter_pkg.sv
// Shared types and the lane-mapping helper for the word-to-byte splitter.
package splitter_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = 4;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef byte_t [NUM_BYTES-1:0] lanes_t;

  // Element 0 is lane O1; big-endian puts the most significant byte there.
  function automatic lanes_t map_lanes(input logic [NUM_BYTES*BYTE_W-1:0] word,
                                       input logic little_endian);
    lanes_t lanes;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (little_endian) begin
        lanes[i] = word[BYTE_W*i +: BYTE_W];
      end else begin
        lanes[i] = word[BYTE_W*(NUM_BYTES-1-i) +: BYTE_W];
      end
    end
    return lanes;
  endfunction

endpackage

// File: rtl/splitter_lane_reg.sv
// One byte lane: 8-bit register with sync reset and load enable.
// With SPLITTER_PARITY_EN defined it also registers the even parity of the loaded byte.
module splitter_lane_reg #(
  parameter logic [7:0] ResetVal = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
`ifdef SPLITTER_PARITY_EN
  output logic       parity_o,
`endif
  output logic [7:0] lane_o
);

  logic [7:0] lane_d, lane_q;

  always_comb begin
    lane_d = lane_q;
    if (load_i) begin
      lane_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q <= ResetVal;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign lane_o = lane_q;

`ifdef SPLITTER_PARITY_EN
  logic parity_d, parity_q;

  always_comb begin
    parity_d = parity_q;
    if (load_i) begin
      parity_d = ^data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_o = parity_q;
`endif

endmodule

// File: rtl/word_byte_splitter.sv
// Splits a 32-bit word into four registered byte lanes behind a valid/ready stage.
// Optional SPLITTER_PARITY_EN adds a registered per-lane parity output P.
module word_byte_splitter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_BYTES = 4,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              little_endian,
  output logic [7:0]        O1,
  output logic [7:0]        O2,
  output logic [7:0]        O3,
  output logic [7:0]        O4,
`ifdef SPLITTER_PARITY_EN
  output logic [3:0]        P,
`endif
  output logic              out_valid,
  input  logic              out_ready
);

  import splitter_pkg::*;

  logic   out_valid_d, out_valid_q;
  logic   accept;
  lanes_t lanes_in;
  lanes_t lanes_q;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign lanes_in = map_lanes(A, little_endian);

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

`ifdef SPLITTER_PARITY_EN
  logic [NUM_BYTES-1:0] parity_q;
`endif

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    splitter_lane_reg #(
      .ResetVal(RESET_VAL)
    ) u_lane (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (accept),
      .data_i  (lanes_in[i]),
`ifdef SPLITTER_PARITY_EN
      .parity_o(parity_q[i]),
`endif
      .lane_o  (lanes_q[i])
    );
  end

  assign O1        = lanes_q[0];
  assign O2        = lanes_q[1];
  assign O3        = lanes_q[2];
  assign O4        = lanes_q[3];
  assign out_valid = out_valid_q;

`ifdef SPLITTER_PARITY_EN
  assign P = parity_q;
`endif

endmodule

// File: tb/tb_word_byte_splitter.sv
// Directed, table-driven bench for word_byte_splitter; covers parity when SPLITTER_PARITY_EN is set.
module tb_word_byte_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A;
  logic        in_valid;
  logic        in_ready;
  logic        little_endian;
  logic [7:0]  O1, O2, O3, O4;
  logic        out_valid;
  logic        out_ready;
`ifdef SPLITTER_PARITY_EN
  logic [3:0]  P;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  word_byte_splitter dut (
    .clk          (clk),
    .rst          (rst),
    .A            (A),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .little_endian(little_endian),
    .O1           (O1),
    .O2           (O2),
    .O3           (O3),
    .O4           (O4),
`ifdef SPLITTER_PARITY_EN
    .P            (P),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  typedef struct {
    logic [31:0] a;
    logic        le;
    logic [31:0] exp_lanes;  // {O1, O2, O3, O4}
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Parity bit i covers lane O(i+1).
  function automatic logic [3:0] exp_parity(input logic [31:0] lanes);
    return {^lanes[7:0], ^lanes[15:8], ^lanes[23:16], ^lanes[31:24]};
  endfunction

  task automatic chk_out(input string name, input logic [31:0] exp_lanes, input logic exp_valid);
    chk({name, " lanes"}, {O1, O2, O3, O4}, exp_lanes);
    chk({name, " out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
`ifdef SPLITTER_PARITY_EN
    chk({name, " parity"}, {28'd0, P}, {28'd0, exp_parity(exp_lanes)});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[1] = '{32'h1111_1111, 1'b0, 32'h1111_1111};
    vecs[2] = '{32'h0000_2222, 1'b0, 32'h0000_2222};
    vecs[3] = '{32'h0000_3333, 1'b0, 32'h0000_3333};
    vecs[4] = '{32'h0102_0304, 1'b0, 32'h0102_0304};
    vecs[5] = '{32'h0102_0304, 1'b1, 32'h0403_0201};
    vecs[6] = '{32'hA5C3_0F80, 1'b1, 32'h800F_C3A5};
    vecs[7] = '{32'hFE01_7F80, 1'b0, 32'hFE01_7F80};

    rst = 1'b1; A = '0; in_valid = 1'b0; little_endian = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk_out("reset", 32'h0000_0000, 1'b0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Idle with empty stage: nothing changes.
    tick();
    chk_out("idle", 32'h0000_0000, 1'b0);

    // Continuous flow: each word replaces the previous one in the same edge.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      A = vecs[i].a; little_endian = vecs[i].le; in_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_lanes, 1'b1);
    end

    // Drain: lanes keep their last values.
    in_valid = 1'b0; A = 32'h5555_5555;
    tick();
    chk_out("drain", 32'hFE01_7F80, 1'b0);

    // Backpressure.
    A = 32'hAABB_CCDD; little_endian = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk_out("bp accept", 32'hAABB_CCDD, 1'b1);
    A = 32'h1234_5678; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d in_ready", i), {31'd0, in_ready}, 32'd0);
      tick();
      chk_out($sformatf("bp%0d hold", i), 32'hAABB_CCDD, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("bp release", 32'h1234_5678, 1'b1);

    // Reset mid-stream while stalled.
    A = 32'hDEAD_BEEF;
    tick();
    chk_out("mid load", 32'hDEAD_BEEF, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_out("mid reset", 32'h0000_0000, 1'b0);
    chk("mid reset in_ready", {31'd0, in_ready}, 32'd1);

    // Reset beats a simultaneous accept.
    A = 32'h0102_0304; in_valid = 1'b1; out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk_out("rst priority", 32'h0000_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
